sword_serial_shifter: RTL and testbench
=======================================

SWORD_SERIAL_SHIFTER -- requirements
Module: sword_serial_shifter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, number of bits per frame; legal range 8..128.
REQ-002 SHALL have parameter CLK_DIV, default 4, system cycles per serial half-period; legal range 2..255.
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 shifts bit DATA_W-1 first, 0 shifts bit 0 first.
REQ-004 SI_ClkIn  in  1  single system clock; all logic on its rising edge.
REQ-005 SI_Reset_N  in  1  reset, asynchronous assert, active-low.
REQ-006 load_valid  in  1  frame offered.
REQ-007 load_data  in  DATA_W  frame contents, sampled when load_valid and load_ready are both high.
REQ-008 load_ready  out  1  frame can be accepted this cycle.
REQ-009 busy  out  1  high whenever state is not IDLE or a pending frame exists.
REQ-010 sh_clk  out  1  serial shift clock to external shift-register chain.
REQ-011 sh_do  out  1  serial data, stable around every sh_clk rising edge.
REQ-012 sh_pen  out  1  active-high parallel-latch pulse after a complete frame.
REQ-013 sh_clr_n  out  1  active-low clear to external chain.

Function
REQ-014 SHALL derive a one-cycle tick every CLK_DIV cycles from a counter that restarts at 0 on every state entry.
REQ-015 SHALL implement states CLEAR, IDLE, SHIFT_LO, SHIFT_HI, LATCH.
REQ-016 CLEAR: sh_clr_n=0 for CLK_DIV cycles after reset release, then IDLE with sh_clr_n=1.
REQ-017 Accept (valid&ready) in IDLE: frame loads into the shift register, state SHIFT_LO next cycle, first bit on sh_do that same next cycle.
REQ-018 SHIFT_LO: sh_clk=0, sh_do=current bit, lasts CLK_DIV cycles, then SHIFT_HI.
REQ-019 SHIFT_HI: sh_clk=1, sh_do unchanged, lasts CLK_DIV cycles; bit counter increments; back to SHIFT_LO if bits remain, else LATCH.
REQ-020 LATCH: sh_clk=0, sh_pen=1, sh_do=0, lasts CLK_DIV cycles.
REQ-021 Frame duration from accept to LATCH exit: exactly (2*DATA_W+1)*CLK_DIV cycles.
REQ-022 SHALL hold a one-deep pending buffer; load_ready = not pending_valid.
REQ-023 Accept while not IDLE (or not CLEAR-complete) writes the pending buffer; no frame is ever dropped or overwritten.
REQ-024 LATCH exit with pending valid: SHIFT_LO of the pending frame next cycle, pending cleared, no IDLE cycle between frames.
REQ-025 LATCH exit with no pending but accept in the same cycle: that frame starts directly as in REQ-017.
REQ-026 load_ready SHALL be high during CLEAR, and frames accepted in CLEAR SHALL go to pending.
REQ-027 Bit counter width SHALL be clog2(DATA_W+1); divider width clog2(CLK_DIV).

Reset
REQ-028 Reset assertion SHALL immediately force: state CLEAR, sh_clk=0, sh_do=0, sh_pen=0, sh_clr_n=0, busy=1, pending_valid=0, counters 0, load_ready=1.
REQ-029 Reset mid-frame SHALL abandon the frame and pending data with no sh_pen pulse.

Structure
REQ-030 State encoding and default parameter constants SHALL live in shared package sword_io_pkg.
REQ-031 Divider/tick SHALL be sub-module serial_tick_gen (params CLK_DIV; ports clock, reset, restart, tick).
REQ-032 Two instances SHALL serve the board: DATA_W=64 for 7-segment, DATA_W=16 for LEDs.

Verification
REQ-033 Reset release, DATA_W=16, CLK_DIV=2 -> sh_clr_n low 2 cycles after release, then IDLE, busy=0.
REQ-034 Load 16'hA5C3, MSB_FIRST=1 -> 16 sh_clk rising edges sampling 1010_0101_1100_0011, one sh_pen pulse 2 cycles wide, IDLE 66 cycles after accept.
REQ-035 Same with MSB_FIRST=0 -> sampled sequence 1100_0011_1010_0101.
REQ-036 Load 16'h0001 then 16'hFFFF during first frame, third load attempted -> load_ready=0 for third; second frame SHIFT_LO starts cycle after first LATCH ends; both frames exact.
REQ-037 Reset asserted at bit 7 of a frame -> all outputs at reset values same cycle, no sh_pen, next frame after CLEAR correct.
REQ-038 Accept in exact LATCH-exit cycle with empty pending -> frame starts next cycle, pending stays empty.

Source files
------------

// File: rtl/sword_io_pkg.sv
// Shared definitions for the serial shift-register drivers: FSM encoding and the
// default/board frame sizes.
package sword_io_pkg;

  typedef enum logic [2:0] {
    StClear   = 3'd0,
    StIdle    = 3'd1,
    StShiftLo = 3'd2,
    StShiftHi = 3'd3,
    StLatch   = 3'd4
  } sword_state_e;

  localparam int unsigned DefaultDataW    = 64;
  localparam int unsigned DefaultClkDiv   = 4;
  localparam int unsigned DefaultMsbFirst = 1;

  // Board instances: 7-segment chain and discrete LED chain.
  localparam int unsigned SegDataW = 64;
  localparam int unsigned LedDataW = 16;

endpackage

// File: rtl/serial_tick_gen.sv
// Divider producing a one-cycle tick every CLK_DIV cycles; restart_i forces the
// count back to zero so every FSM state starts a fresh period.
module serial_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntMax);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sword_serial_shifter.sv
// Serialises DATA_W-bit frames onto an external shift-register chain
// (clock/data/latch/clear) with a one-deep pending buffer for back-to-back frames.
module sword_serial_shifter
  import sword_io_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned CLK_DIV   = DefaultClkDiv,
  parameter int unsigned MSB_FIRST = DefaultMsbFirst
) (
  input  logic              SI_ClkIn,
  input  logic              SI_Reset_N,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              busy,
  output logic              sh_clk,
  output logic              sh_do,
  output logic              sh_pen,
  output logic              sh_clr_n
);

  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  sword_state_e      state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;

  logic tick;
  logic restart;
  logic accept;
  logic start_frame;
  logic bit_done;
  logic out_bit;

  assign load_ready = ~pend_valid_q;
  assign accept     = load_valid & load_ready;

  // IDLE holds the divider at zero so a frame start always begins a full period.
  assign restart = (state_d != state_q) || (state_q == StIdle);

  serial_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_i     (SI_ClkIn),
    .rst_ni    (SI_Reset_N),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // A new frame launches from IDLE or straight out of the final LATCH cycle.
  assign start_frame = ((state_q == StIdle) || ((state_q == StLatch) && tick)) &&
                       (pend_valid_q || accept);
  assign bit_done    = (state_q == StShiftHi) && tick;

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      state_q <= StClear;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: begin
        if (tick) state_d = StIdle;
      end
      StIdle: begin
        if (start_frame) state_d = StShiftLo;
      end
      StShiftLo: begin
        if (tick) state_d = StShiftHi;
      end
      StShiftHi: begin
        if (tick) state_d = (bit_cnt_q == BitLast) ? StLatch : StShiftLo;
      end
      StLatch: begin
        if (tick) state_d = start_frame ? StShiftLo : StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;

    if (start_frame) begin
      sr_d      = pend_valid_q ? pend_data_q : load_data;
      bit_cnt_d = '0;
    end else if (bit_done) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (MSB_FIRST != 0) begin
        sr_d = {sr_q[DATA_W-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[DATA_W-1:1]};
      end
    end

    // accept only happens with the buffer empty, so these never collide.
    if (start_frame && pend_valid_q) begin
      pend_valid_d = 1'b0;
    end
    if (accept && !start_frame) begin
      pend_valid_d = 1'b1;
      pend_data_d  = load_data;
    end
  end

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
    end else begin
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
    end
  end

  assign out_bit = (MSB_FIRST != 0) ? sr_q[DATA_W-1] : sr_q[0];

  always_comb begin
    sh_clk   = (state_q == StShiftHi);
    sh_do    = ((state_q == StShiftLo) || (state_q == StShiftHi)) ? out_bit : 1'b0;
    sh_pen   = (state_q == StLatch);
    sh_clr_n = (state_q != StClear);
    busy     = (state_q != StIdle) || pend_valid_q;
  end

endmodule

// File: tb/tb_sword_serial_shifter.sv
// Bench for sword_serial_shifter: frame-schedule model checked every cycle against
// an MSB-first and an LSB-first instance, plus literal checks on directed frames.
module tb_sword_serial_shifter;

  localparam int DW = 16;
  localparam int CD = 2;
  localparam int FL = (2 * DW + 1) * CD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid;
  logic [DW-1:0] load_data;

  logic m_ready, m_busy, m_clk, m_do, m_pen, m_clr_n;
  logic l_ready, l_busy, l_clk, l_do, l_pen, l_clr_n;

  always #5 clk = ~clk;

  sword_serial_shifter #(.DATA_W(DW), .CLK_DIV(CD), .MSB_FIRST(1)) u_msb (
    .SI_ClkIn   (clk),
    .SI_Reset_N (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (m_ready),
    .busy       (m_busy),
    .sh_clk     (m_clk),
    .sh_do      (m_do),
    .sh_pen     (m_pen),
    .sh_clr_n   (m_clr_n)
  );

  sword_serial_shifter #(.DATA_W(DW), .CLK_DIV(CD), .MSB_FIRST(0)) u_lsb (
    .SI_ClkIn   (clk),
    .SI_Reset_N (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (l_ready),
    .busy       (l_busy),
    .sh_clk     (l_clk),
    .sh_do      (l_do),
    .sh_pen     (l_pen),
    .sh_clr_n   (l_clr_n)
  );

  int checks = 0;
  int failures = 0;
  bit tb_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each accepted frame owns a start cycle; outputs follow from (t - start).
  int          cyc = 0;
  bit          in_rst = 1'b1;
  int          rel_cyc = 0;
  int          nfr = 0;
  int          fr_base = 0;
  int          fr_acc[32];
  int          fr_start[32];
  logic [DW-1:0] fr_data[32];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_at(input int t, input bit msb, output logic e_clk,
                                   output logic e_do, output logic e_pen, output logic e_clrn,
                                   output logic e_busy, output logic e_ready);
    e_clk = 0; e_do = 0; e_pen = 0; e_clrn = 1; e_busy = 0; e_ready = 1;
    if (in_rst) begin
      e_clrn = 0;
      e_busy = 1;
    end else begin
      if (t < rel_cyc + CD) begin
        e_clrn = 0;
        e_busy = 1;
      end
      for (int i = fr_base; i < nfr; i++) begin
        if (fr_acc[i] < t && fr_start[i] > t) begin
          e_busy  = 1;
          e_ready = 0;
        end
        if (t >= fr_start[i] && t < fr_start[i] + FL) begin
          int p;
          int k;
          p = (t - fr_start[i]) / CD;
          e_busy = 1;
          if (p < 2 * DW) begin
            k     = p / 2;
            e_clk = p[0];
            e_do  = msb ? fr_data[i][DW-1-k] : fr_data[i][k];
          end else begin
            e_pen = 1;
          end
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    logic c, d, p, cl, b, r;
    if (!tb_done) begin
      model_at(cyc, 1'b1, c, d, p, cl, b, r);
      chk("msb.sh_clk", m_clk, c);
      chk("msb.sh_do", m_do, d);
      chk("msb.sh_pen", m_pen, p);
      chk("msb.sh_clr_n", m_clr_n, cl);
      chk("msb.busy", m_busy, b);
      chk("msb.load_ready", m_ready, r);
      model_at(cyc, 1'b0, c, d, p, cl, b, r);
      chk("lsb.sh_clk", l_clk, c);
      chk("lsb.sh_do", l_do, d);
      chk("lsb.sh_pen", l_pen, p);
      chk("lsb.sh_clr_n", l_clr_n, cl);
      chk("lsb.busy", l_busy, b);
      chk("lsb.load_ready", l_ready, r);
    end
  end

  // Edge monitors feeding the literal checks.
  int          rises_m = 0, rises_l = 0, pen_cyc_m = 0, pen_pulse_m = 0, busy_cyc_m = 0;
  logic [63:0] seq_m = '0, seq_l = '0;
  logic        prev_clk_m = 0, prev_clk_l = 0, prev_pen_m = 0;

  always @(negedge clk) begin
    if (m_clk && !prev_clk_m) begin
      rises_m++;
      seq_m = {seq_m[62:0], m_do};
    end
    if (l_clk && !prev_clk_l) begin
      rises_l++;
      seq_l = {seq_l[62:0], l_do};
    end
    if (m_pen) pen_cyc_m++;
    if (m_pen && !prev_pen_m) pen_pulse_m++;
    if (m_busy) busy_cyc_m++;
    prev_clk_m = m_clk;
    prev_clk_l = l_clk;
    prev_pen_m = m_pen;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; offers one frame for one cycle and records it if the model accepts.
  task automatic offer(input logic [DW-1:0] d);
    logic c, dd, p, cl, b, r;
    model_at(cyc, 1'b1, c, dd, p, cl, b, r);
    load_valid = 1'b1;
    load_data  = d;
    if (r) begin
      fr_acc[nfr]   = cyc;
      fr_data[nfr]  = d;
      fr_start[nfr] = cyc + 1;
      if (nfr > fr_base && fr_start[nfr-1] + FL > cyc + 1) fr_start[nfr] = fr_start[nfr-1] + FL;
      nfr++;
    end
    step(1);
    load_valid = 1'b0;
  endtask

  int b0, r0, rl0, pc0, pp0;

  task automatic snap();
    b0 = busy_cyc_m; r0 = rises_m; rl0 = rises_l; pc0 = pen_cyc_m; pp0 = pen_pulse_m;
  endtask

  initial begin
    load_valid = 1'b0;
    load_data  = '0;
    step(3);
    rst_n = 1'b1; in_rst = 1'b0; rel_cyc = cyc;
    @(negedge clk); chk("clr_n_rel_cycle0", m_clr_n, 0);
    @(negedge clk); chk("clr_n_rel_cycle1", m_clr_n, 0);
    @(negedge clk); chk("clr_n_after_clear", m_clr_n, 1); chk("busy_idle", m_busy, 0);
    step(1);

    // Single frame, both bit orders.
    snap();
    offer(16'hA5C3);
    step(78);
    chk("a5c3_msb_seq", seq_m[15:0], 16'hA5C3);
    chk("a5c3_lsb_seq", seq_l[15:0], 16'hC3A5);
    chk("a5c3_msb_rises", rises_m - r0, 16);
    chk("a5c3_lsb_rises", rises_l - rl0, 16);
    chk("a5c3_pen_width", pen_cyc_m - pc0, 2);
    chk("a5c3_pen_pulses", pen_pulse_m - pp0, 1);
    chk("a5c3_busy_cycles", busy_cyc_m - b0, 66);

    // Back-to-back via pending buffer, third offer refused.
    snap();
    offer(16'h0001);
    step(4);
    offer(16'hFFFF);
    step(4);
    chk("third_load_ready", m_ready, 0);
    offer(16'h5555);
    step(140);
    chk("b2b_busy_cycles", busy_cyc_m - b0, 132);
    chk("b2b_rises", rises_m - r0, 32);
    chk("b2b_pen_pulses", pen_pulse_m - pp0, 2);
    chk("b2b_msb_seq", seq_m[31:0], 32'h0001_FFFF);
    chk("b2b_lsb_seq", seq_l[31:0], 32'h8000_FFFF);

    // Accept in the last LATCH cycle with an empty buffer.
    snap();
    offer(16'h1234);
    step(65);
    offer(16'hF00F);
    chk("latch_exit_pend_empty", m_ready, 1);
    step(140);
    chk("latch_exit_busy_cycles", busy_cyc_m - b0, 132);
    chk("latch_exit_seq", seq_m[31:0], 32'h1234_F00F);
    chk("latch_exit_rises", rises_m - r0, 32);

    // Reset in the middle of bit 7.
    snap();
    offer(16'hBEEF);
    step(29);
    #2;
    rst_n = 1'b0; in_rst = 1'b1; fr_base = nfr;
    #1;
    chk("rst_sh_clk", m_clk, 0);
    chk("rst_sh_do", m_do, 0);
    chk("rst_sh_pen", m_pen, 0);
    chk("rst_sh_clr_n", m_clr_n, 0);
    chk("rst_busy", m_busy, 1);
    chk("rst_load_ready", m_ready, 1);
    step(3);
    rst_n = 1'b1; in_rst = 1'b0; rel_cyc = cyc;
    step(4);
    chk("rst_no_pen", pen_pulse_m - pp0, 0);
    snap();
    offer(16'h3C5A);
    step(70);
    chk("post_rst_msb_seq", seq_m[15:0], 16'h3C5A);
    chk("post_rst_lsb_seq", seq_l[15:0], 16'h5A3C);
    chk("post_rst_rises", rises_m - r0, 16);
    chk("post_rst_pen", pen_pulse_m - pp0, 1);

    tb_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
